// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational instruction memory
// and buffers {pc, instruction} pairs in a 2-entry queue for decode.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 16,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];

    logic [31:0] word_idx;
    logic        in_range;
    logic        pop;
    logic        space;
    logic        push;

    assign word_idx  = {2'b00, pc_q[31:2]};
    assign in_range  = word_idx < 32'(IMEM_WORDS);
    assign imem_addr = pc_q;
    assign if_valid  = (count_q != 2'd0);
    assign if_pc     = q_pc[rd_ptr_q];
    assign if_instr  = q_instr[rd_ptr_q];
    assign halted    = (state_q == HALT);

    // A redirect squashes whatever fetch is happening this cycle, so it gates push.
    assign pop   = if_valid & if_ready;
    assign space = (count_q < 2'(QDEPTH)) | pop;
    assign push  = (state_q == FETCH) & space & in_range & ~redirect_valid;

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en) state_d = FETCH;
                FETCH:   if (!in_range) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Head comes straight from these registers, keeping imem_instr off the decode path.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_pc[0]    <= 32'd0;
            q_pc[1]    <= 32'd0;
            q_instr[0] <= 32'd0;
            q_instr[1] <= 32'd0;
        end else if (push) begin
            q_pc[wr_ptr_q]    <= pc_q;
            q_instr[wr_ptr_q] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus queues the expected deliveries,
// a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] imem [0:15];
    int          testsRun = 0;
    int          testsFailed = 0;

    fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(16),
        .QDEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = (imem_addr[31:6] == 26'd0) ? imem[imem_addr[5:2]] : 32'hdead_beef;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic fe, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
    endtask

    task automatic expectRange(input logic [31:0] firstPc, input logic [31:0] lastPc);
        for (logic [31:0] p = firstPc; p <= lastPc; p += 32'd4) begin
            expQ.push_back('{pc: p, instr: imem[p[5:2]]});
        end
    endtask

    task automatic waitHalted(input int limit);
        int n = 0;
        while (!halted && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic waitDrained(input int limit);
        int n = 0;
        while (if_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("queue_drained", {31'd0, if_valid}, 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: every accepted head must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && if_valid && if_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_delivery: got pc 0x%08h instr 0x%08h, expected none", if_pc, if_instr);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("deliver_pc", if_pc, e.pc);
                checkOutput("deliver_instr", if_instr, e.instr);
            end
        end
    end

    initial begin
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h00a0_0113;
        imem[2] = 32'h0020_81b3;
        for (int i = 3; i < 16; i++) imem[i] = 32'h0000_0013 + (32'(i) << 20);

        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_ready       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("idle_imem_addr", imem_addr, 32'd0);
        checkOutput("idle_if_valid", {31'd0, if_valid}, 32'd0);

        // Back-pressure: queue fills with pc 0 and 4, pc parks at 8
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("bp_if_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("bp_if_pc", if_pc, 32'h0);
        checkOutput("bp_if_instr", if_instr, 32'h0050_0093);
        checkOutput("bp_pc_hold", imem_addr, 32'h8);
        @(negedge clk);
        checkOutput("bp_if_pc_stable", if_pc, 32'h0);
        checkOutput("bp_pc_hold2", imem_addr, 32'h8);

        // Release: one per cycle up to 0x3C, halt exactly after the 0x40 detection
        expectRange(32'h0, 32'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (15) @(negedge clk);
        checkOutput("pre_halt", {31'd0, halted}, 32'd0);
        @(negedge clk);
        checkOutput("halt_on_time", {31'd0, halted}, 32'd1);
        checkOutput("last_pc", if_pc, 32'h3C);
        @(negedge clk);
        checkOutput("halt_drained", {31'd0, if_valid}, 32'd0);
        checkOutput("run_scoreboard_empty", 32'(expQ.size()), 32'd0);

        // Redirect out of HALT with decode stalled
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("unhalt", {31'd0, halted}, 32'd0);
        checkOutput("unhalt_if_valid", {31'd0, if_valid}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("resume_if_pc", if_pc, 32'h10);
        checkOutput("resume_pc_hold", imem_addr, 32'h18);

        // Redirect while full flushes 0x10/0x14; target low bits are dropped
        expectRange(32'h08, 32'h3C);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_000A, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("flush_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("flush_pc", imem_addr, 32'h08);
        waitHalted(100);
        waitDrained(10);

        // Redirect with a concurrent pop: head 0x20 is accepted, 0x24 is discarded
        expQ.push_back('{pc: 32'h20, instr: imem[8]});
        expectRange(32'h30, 32'h3C);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h30, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        waitHalted(100);
        waitDrained(10);

        // Reset mid-stream overrides fetch_en and discards the queue
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_if_valid", {31'd0, if_valid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("mid_rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("mid_rst_imem_addr", imem_addr, 32'd0);
        checkOutput("mid_rst_if_pc", if_pc, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("post_rst_no_fetch", {31'd0, if_valid}, 32'd0);
        checkOutput("post_rst_pc", imem_addr, 32'd0);

        expectRange(32'h0, 32'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        waitHalted(100);
        waitDrained(10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
